// File: rtl/led_sequencer_pkg.sv
// Shared helpers for led_sequencer: step period sizing, power-up table pattern and length clamp.
package led_sequencer_pkg;

  function automatic int step_count(real freq, real period);
    int c;
    c = int'(freq * period);
    return (c < 1) ? 1 : c;
  endfunction

  // Even entries dark, odd entries walk a single lit LED: off, LED0, off, LED1, ...
  function automatic logic [31:0] reset_mask(int k, int n);
    logic [31:0] m;
    m = '0;
    if ((k % 2) == 1) m[(k >> 1) % n] = 1'b1;
    return m;
  endfunction

  function automatic int unsigned eff_len(int unsigned num, int unsigned depth);
    if (num == 0) return 1;
    if (num > depth) return depth;
    return num;
  endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter and duty compare; all-ones brightness means fully on.
module led_pwm #(
  parameter int PWM_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PWM_WIDTH-1:0] brightness,
  output logic                 pwm_on
);

  logic [PWM_WIDTH-1:0] p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else        p <= p + 1'b1;
  end

  assign pwm_on = (&brightness) || (p < brightness);

endmodule

// File: rtl/led_sequencer.sv
// Steps NUM_LEDS outputs through a writable mask table at a fixed period, gated by shared PWM.
// Outputs are registered with one cycle of latency; enable=0 freezes the sequence and blanks LEDs.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter real CLK_FREQUENCY = 100.0e6,
  parameter real STEP_PERIOD   = 0.25,
  parameter int  NUM_LEDS      = 3,
  parameter int  DEPTH         = 4,
  parameter int  PWM_WIDTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [$clog2(DEPTH+1)-1:0] num_steps,
  input  logic [PWM_WIDTH-1:0]       brightness,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [NUM_LEDS-1:0]        wr_data,
  output logic [NUM_LEDS-1:0]        led,
  output logic                       step_strobe,
  output logic [$clog2(DEPTH)-1:0]   step_index
);

  localparam int STEP_COUNT = step_count(CLK_FREQUENCY, STEP_PERIOD);
  localparam int PSW        = (STEP_COUNT > 1) ? $clog2(STEP_COUNT) : 1;

  logic [PSW-1:0]      presc;
  logic                tick;
  logic                pwm_on;
  int unsigned         len;
  logic [NUM_LEDS-1:0] step_tab [DEPTH];

  assign tick = enable && (32'(presc) == STEP_COUNT - 1);

  always_comb begin
    len = eff_len(32'(num_steps), DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (enable) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // An index left beyond a shrunken length still wraps to 0 on the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_index  <= '0;
      step_strobe <= 1'b0;
    end else begin
      step_strobe <= tick;
      if (tick) begin
        if (32'(step_index) >= len - 1) step_index <= '0;
        else                            step_index <= step_index + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) step_tab[k] <= NUM_LEDS'(reset_mask(k, NUM_LEDS));
    end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
      step_tab[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= '0;
    else        led <= enable ? (step_tab[step_index] & {NUM_LEDS{pwm_on}}) : '0;
  end

  led_pwm #(
    .PWM_WIDTH(PWM_WIDTH)
  ) u_pwm (
    .clk        (clk),
    .rst_n      (rst_n),
    .brightness (brightness),
    .pwm_on     (pwm_on)
  );

endmodule
